// File: rtl/s_div_share_ctrl_pkg.sv
// s_div_share_ctrl_pkg: shared state encoding and array-level defaults for the shared divider
package s_div_share_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} div_share_state_t;
  localparam int N_DIV_REQ = 4;
  localparam int N_DIV_BITS = 32;
endpackage

// File: rtl/s_div_share_ctrl_if.sv
// s_div_share_ctrl_if: request/response bundle between the PE array and the shared divider
interface s_div_share_ctrl_if
  import s_div_share_ctrl_pkg::*;
#(
  parameter int N_REQ = N_DIV_REQ,
  parameter int N_BITS = N_DIV_BITS
);
  logic pea_ready_i;
  logic [N_REQ-1:0] req_valid_i;
  logic [N_REQ-1:0][N_BITS-1:0] req_a_i;
  logic [N_REQ-1:0][N_BITS-1:0] req_b_i;
  logic [N_REQ-1:0] req_rem_i;
  logic [N_REQ-1:0] req_ready_o;
  logic [N_REQ-1:0] rsp_valid_o;
  logic [N_BITS-1:0] rsp_res_o;
  logic [N_BITS-1:0] rsp_rem_q_o;
  logic busy_o;
  modport slave (
    input pea_ready_i, req_valid_i, req_a_i, req_b_i, req_rem_i,
    output req_ready_o, rsp_valid_o, rsp_res_o, rsp_rem_q_o, busy_o
  );
  modport master (
    output pea_ready_i, req_valid_i, req_a_i, req_b_i, req_rem_i,
    input req_ready_o, rsp_valid_o, rsp_res_o, rsp_rem_q_o, busy_o
  );
endinterface

// File: rtl/s_div_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from the slot after ptr_i
module rr_arbiter
  import s_div_share_ctrl_pkg::*;
#(
  parameter int N_REQ = N_DIV_REQ,
  parameter int LOG_N_REQ = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [LOG_N_REQ-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [LOG_N_REQ-1:0] idx_o
);
  logic found;
  int k;
  // first set request walking ptr+1, ptr+2, ... with wrap-around
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = (int'(ptr_i) + i) % N_REQ;
      if (!found && req_i[k]) begin
        found = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o = LOG_N_REQ'(k);
      end
    end
  end
endmodule

// File: rtl/s_div_share_ctrl.sv
// s_div_share_ctrl: one radix-2 restoring divider shared round-robin among N_REQ PEs
module s_div_share_ctrl
  import s_div_share_ctrl_pkg::*;
#(
  parameter int N_REQ = N_DIV_REQ,
  parameter int N_BITS = N_DIV_BITS,
  parameter int LOG_N_REQ = $clog2(N_REQ)
) (
  input logic clk_i,
  input logic rst_n_i,
  s_div_share_ctrl_if.slave bus
);
  localparam int CW = $clog2(N_BITS);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_DONE = DONE;
  logic [1:0] state_q, state_d;
  logic [LOG_N_REQ-1:0] ptr_q, ptr_d, own_q, own_d, idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N_BITS-1:0] r_q, r_d, q_q, q_d, b_q, b_d;
  logic rem_q, rem_d;
  logic [N_REQ-1:0] gnt;
  logic [N_BITS:0] rs, trial;
  rr_arbiter #(.N_REQ(N_REQ), .LOG_N_REQ(LOG_N_REQ)) u_arb (
    .req_i(bus.req_valid_i),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(idx)
  );
  // one restoring step: shift {R,Q} left, try subtracting the divisor
  assign rs = {r_q, q_q[N_BITS-1]};
  assign trial = rs - {1'b0, b_q};
  // grant only in IDLE, and never while reset holds the controller
  assign bus.req_ready_o = (rst_n_i && state_q == S_IDLE) ? gnt : '0;
  assign bus.rsp_valid_o = (state_q == S_DONE) ? (N_REQ'(1) << own_q) : '0;
  assign bus.rsp_res_o = rem_q ? r_q : q_q;
  assign bus.rsp_rem_q_o = rem_q ? q_q : r_q;
  assign bus.busy_o = state_q != S_IDLE;
  // next-state: accept and seed, iterate, then hold the response until taken
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    own_d = own_q;
    cnt_d = cnt_q;
    r_d = r_q;
    q_d = q_q;
    b_d = b_q;
    rem_d = rem_q;
    case (state_q)
      S_IDLE: if (|bus.req_valid_i) begin
        own_d = idx;
        b_d = bus.req_b_i[idx];
        rem_d = bus.req_rem_i[idx];
        state_d = (bus.req_b_i[idx] == '0) ? S_DONE : S_CALC;
        q_d = (bus.req_b_i[idx] == '0) ? '1 : bus.req_a_i[idx];
        r_d = (bus.req_b_i[idx] == '0) ? bus.req_a_i[idx] : '0;
        cnt_d = CW'(N_BITS - 1);
      end
      S_CALC: begin
        r_d = trial[N_BITS] ? rs[N_BITS-1:0] : trial[N_BITS-1:0];
        q_d = {q_q[N_BITS-2:0], ~trial[N_BITS]};
        state_d = (cnt_q == '0) ? S_DONE : S_CALC;
        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      end
      S_DONE: if (bus.pea_ready_i) begin
        ptr_d = own_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state registers; reset aborts any operation and restarts priority at index 0
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      ptr_q <= LOG_N_REQ'(N_REQ - 1);
      own_q <= '0;
      cnt_q <= '0;
      r_q <= '0;
      q_q <= '0;
      b_q <= '0;
      rem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      cnt_q <= cnt_d;
      r_q <= r_d;
      q_q <= q_d;
      b_q <= b_d;
      rem_q <= rem_d;
    end
  end
endmodule

// File: tb/tb_s_div_share_ctrl.sv
// tb_s_div_share_ctrl: directed vectors and corner sequences for the shared divider
module tb_s_div_share_ctrl;
  localparam int NR = 4;
  localparam int NB = 32;
  typedef struct {
    int p;
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic rem;
    logic [NB-1:0] res;
    logic [NB-1:0] oth;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  vec_t tv[9];
  vec_t rr[4];
  s_div_share_ctrl_if #(.N_REQ(NR), .N_BITS(NB)) bus ();
  s_div_share_ctrl #(.N_REQ(NR), .N_BITS(NB)) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wait_gnt();
    int n;
    n = 0;
    #1;
    while (bus.req_ready_o == '0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask
  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (bus.rsp_valid_o == '0 && n < 100);
  endtask
  task automatic drive(input vec_t v);
    bus.req_valid_i[v.p] = 1'b1;
    bus.req_a_i[v.p] = v.a;
    bus.req_b_i[v.p] = v.b;
    bus.req_rem_i[v.p] = v.rem;
  endtask
  task automatic chk_rsp(input string name, input vec_t v);
    chk({name, "_valid"}, NB'(bus.rsp_valid_o), NB'(1) << v.p);
    chk({name, "_res"}, bus.rsp_res_o, v.res);
    chk({name, "_oth"}, bus.rsp_rem_q_o, v.oth);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n;
    tv[0] = '{0, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2};
    tv[1] = '{2, 32'hFFFFFFFF, 32'd16, 1'b1, 32'd15, 32'h0FFFFFFF};
    tv[2] = '{1, 32'h1234, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h1234};
    tv[3] = '{3, 32'd5, 32'd9, 1'b0, 32'd0, 32'd5};
    tv[4] = '{0, 32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0};
    tv[5] = '{1, 32'd1000000, 32'd1000, 1'b1, 32'd0, 32'd1000};
    tv[6] = '{2, 32'h80000000, 32'd3, 1'b0, 32'd715827882, 32'd2};
    tv[7] = '{3, 32'h1234, 32'd0, 1'b1, 32'h1234, 32'hFFFFFFFF};
    tv[8] = '{0, 32'd12345, 32'd12345, 1'b0, 32'd1, 32'd0};
    rr[0] = '{0, 32'd50, 32'd5, 1'b0, 32'd10, 32'd0};
    rr[1] = '{1, 32'd51, 32'd4, 1'b0, 32'd12, 32'd3};
    rr[2] = '{2, 32'd77, 32'd10, 1'b0, 32'd7, 32'd7};
    rr[3] = '{3, 32'd9, 32'd2, 1'b0, 32'd4, 32'd1};
    bus.pea_ready_i = 1'b1;
    bus.req_valid_i = '0;
    bus.req_a_i = '0;
    bus.req_b_i = '0;
    bus.req_rem_i = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", NB'(bus.rsp_valid_o), '0);
    chk("rst_busy", NB'(bus.busy_o), '0);
    chk("rst_res", bus.rsp_res_o, '0);
    chk("rst_oth", bus.rsp_rem_q_o, '0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_ready", NB'(bus.req_ready_o), '0);
    // round-robin with all four requesters held valid: order 0,1,2,3,0
    for (int i = 0; i < NR; i++) drive(rr[i]);
    for (int k = 0; k <= NR; k++) begin
      wait_gnt();
      chk("rr_gnt", NB'(bus.req_ready_o), NB'(1) << (k % NR));
      wait_rsp(n);
      chk_rsp("rr", rr[k % NR]);
      @(negedge clk);
    end
    bus.req_valid_i = '0;
    @(negedge clk);
    // table of single requests
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(tv[i]);
      wait_gnt();
      chk("tbl_gnt", NB'(bus.req_ready_o), NB'(1) << tv[i].p);
      @(posedge clk);
      #1;
      bus.req_valid_i = '0;
      wait_rsp(n);
      chk("tbl_lat", NB'(n), (tv[i].b == '0) ? NB'(1) : NB'(NB + 1));
      chk("tbl_busy", NB'(bus.busy_o), NB'(1));
      chk_rsp("tbl", tv[i]);
      @(negedge clk);
      #1;
      chk("tbl_release", NB'(bus.rsp_valid_o), '0);
      chk("tbl_idle", NB'(bus.busy_o), '0);
    end
    // backpressure: p1 then p2 pending, response held for 5 cycles
    bus.pea_ready_i = 1'b0;
    @(negedge clk);
    drive('{1, 32'd100, 32'd10, 1'b0, 32'd10, 32'd0});
    drive('{2, 32'd20, 32'd3, 1'b0, 32'd6, 32'd2});
    wait_gnt();
    chk("bp_gnt1", NB'(bus.req_ready_o), NB'(4'b0010));
    @(posedge clk);
    #1;
    bus.req_valid_i[1] = 1'b0;
    wait_rsp(n);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", NB'(bus.rsp_valid_o), NB'(4'b0010));
      chk("bp_res", bus.rsp_res_o, 32'd10);
      chk("bp_oth", bus.rsp_rem_q_o, 32'd0);
      chk("bp_nogrant", NB'(bus.req_ready_o), '0);
    end
    bus.pea_ready_i = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_gnt2", NB'(bus.req_ready_o), NB'(4'b0100));
    chk("bp_idle", NB'(bus.busy_o), '0);
    @(posedge clk);
    #1;
    bus.req_valid_i[2] = 1'b0;
    wait_rsp(n);
    chk_rsp("bp2", '{2, 32'd20, 32'd3, 1'b0, 32'd6, 32'd2});
    @(negedge clk);
    // reset in CALC at counter 10 aborts; priority restarts at index 0
    @(negedge clk);
    drive('{0, 32'd1000, 32'd7, 1'b0, 32'd142, 32'd6});
    wait_gnt();
    chk("mr_gnt", NB'(bus.req_ready_o), NB'(4'b0001));
    @(posedge clk);
    #1;
    bus.req_valid_i[0] = 1'b0;
    drive('{1, 32'd81, 32'd9, 1'b0, 32'd9, 32'd0});
    drive('{3, 32'd64, 32'd8, 1'b1, 32'd0, 32'd8});
    repeat (22) @(negedge clk);
    #1;
    chk("mr_busy", NB'(bus.busy_o), NB'(1));
    rst_n = 1'b0;
    #1;
    chk("mr_valid", NB'(bus.rsp_valid_o), '0);
    chk("mr_ready", NB'(bus.req_ready_o), '0);
    chk("mr_busy0", NB'(bus.busy_o), '0);
    chk("mr_res", bus.rsp_res_o, '0);
    chk("mr_oth", bus.rsp_rem_q_o, '0);
    @(negedge clk);
    #1;
    chk("mr_hold", NB'(bus.rsp_valid_o), '0);
    rst_n = 1'b1;
    #1;
    chk("mr_regnt", NB'(bus.req_ready_o), NB'(4'b0010));
    @(posedge clk);
    #1;
    bus.req_valid_i[1] = 1'b0;
    wait_rsp(n);
    chk_rsp("mr1", '{1, 32'd81, 32'd9, 1'b0, 32'd9, 32'd0});
    @(negedge clk);
    wait_gnt();
    chk("mr_gnt3", NB'(bus.req_ready_o), NB'(4'b1000));
    @(posedge clk);
    #1;
    bus.req_valid_i[3] = 1'b0;
    wait_rsp(n);
    chk_rsp("mr3", '{3, 32'd64, 32'd8, 1'b1, 32'd0, 32'd8});
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
